// File: rtl/stream_xbar_rsp.sv
// stream_xbar_rsp -- response-return path for a NumInp x NumOut request crossbar.
//
// Every request handshake at crossbar output j records its source index in a
// per-target order FIFO. Target j answers in order, so its response is routed
// to the requester at the head of FIFO j. Each requester round-robins over the
// targets currently offering it a response. A stalled grant is locked so that
// the data, sel and valid outputs stay stable until the handshake completes.
//
// Optional feature macro: STREAM_XBAR_RSP_ORPHAN_EN
//   defined   : a response from a target with an empty FIFO is accepted and
//               dropped, and err_o pulses one cycle later.
//   undefined : such a response is stalled, and err_o is tied to 0.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   req_valid_i  [NumOut]            request valid at crossbar output j
//   req_ready_i  [NumOut]            request ready at output j (already gated by !full_o)
//   req_idx_i    [NumOut][IdxWidth]  source index of the request at output j
//   full_o       [NumOut]            order FIFO j full
//   rsp_data_i   [NumOut][DataWidth] response payload from target j
//   rsp_valid_i  [NumOut]            response valid from target j
//   rsp_ready_o  [NumOut]            response accepted from target j
//   rsp_data_o   [NumInp][DataWidth] response payload to requester i
//   rsp_sel_o    [NumInp][SelWidth]  target the response came from
//   rsp_valid_o  [NumInp]            response valid to requester i
//   rsp_ready_i  [NumInp]            requester i accepts the response
//   err_o                            orphan-response pulse

module stream_xbar_rsp #(
  parameter int NumInp    = 0,
  parameter int NumOut    = 0,
  parameter int DataWidth = 1,
  parameter int Depth     = 4,
  parameter int IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1,
  parameter int SelWidth  = (NumOut > 1) ? $clog2(NumOut) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumOut-1:0]                   req_valid_i,
  input  logic [NumOut-1:0]                   req_ready_i,
  input  logic [NumOut-1:0][IdxWidth-1:0]     req_idx_i,
  output logic [NumOut-1:0]                   full_o,
  input  logic [NumOut-1:0][DataWidth-1:0]    rsp_data_i,
  input  logic [NumOut-1:0]                   rsp_valid_i,
  output logic [NumOut-1:0]                   rsp_ready_o,
  output logic [NumInp-1:0][DataWidth-1:0]    rsp_data_o,
  output logic [NumInp-1:0][SelWidth-1:0]     rsp_sel_o,
  output logic [NumInp-1:0]                   rsp_valid_o,
  input  logic [NumInp-1:0]                   rsp_ready_i,
  output logic                                err_o
);

  localparam int CntWidth = $clog2(Depth + 1);
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  // Order FIFO state, one per target
  logic [NumOut-1:0][Depth-1:0][IdxWidth-1:0] mem_q;
  logic [NumOut-1:0][PtrWidth-1:0]            wr_ptr_q, wr_ptr_d;
  logic [NumOut-1:0][PtrWidth-1:0]            rd_ptr_q, rd_ptr_d;
  logic [NumOut-1:0][CntWidth-1:0]            cnt_q, cnt_d;

  // Per-requester arbitration state
  logic [NumInp-1:0][SelWidth-1:0]            rr_ptr_q, rr_ptr_d;
  logic [NumInp-1:0]                          lock_q, lock_d;
  logic [NumInp-1:0][SelWidth-1:0]            lock_sel_q, lock_sel_d;

  logic [NumOut-1:0]                          full_s;
  logic [NumOut-1:0]                          empty_s;
  logic [NumOut-1:0]                          push_req_s;
  logic [NumOut-1:0]                          push_s;
  logic [NumOut-1:0]                          pop_s;
  logic [NumOut-1:0][IdxWidth-1:0]            head_s;
  logic [NumInp-1:0][NumOut-1:0]              cand_s;
  logic [NumInp-1:0]                          gnt_vld_s;
  logic [NumInp-1:0][SelWidth-1:0]            gnt_sel_s;
  logic [NumOut-1:0]                          rdy_s;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(Depth - 1)) begin
      return '0;
    end else begin
      return p + PtrWidth'(1);
    end
  endfunction

  function automatic logic [SelWidth-1:0] sel_inc(input logic [SelWidth-1:0] s);
    if (s == SelWidth'(NumOut - 1)) begin
      return '0;
    end else begin
      return s + SelWidth'(1);
    end
  endfunction

  // FIFO status, head entries and push/pop qualification
  always_comb begin
    full_s     = '0;
    empty_s    = '0;
    head_s     = '0;
    push_req_s = '0;
    push_s     = '0;
    pop_s      = '0;
    for (int j = 0; j < NumOut; j++) begin
      full_s[j]     = (cnt_q[j] == CntWidth'(Depth));
      empty_s[j]    = (cnt_q[j] == '0);
      head_s[j]     = mem_q[j][rd_ptr_q[j]];
      push_req_s[j] = req_valid_i[j] & req_ready_i[j];
      // only routed responses pop; an orphan never touches the FIFO
      pop_s[j]      = rsp_valid_i[j] & rsp_ready_o[j] & ~empty_s[j];
      // a full FIFO still takes a push when the same cycle frees a slot
      push_s[j]     = push_req_s[j] & (~full_s[j] | pop_s[j]);
    end
  end

  assign full_o = full_s;

  // Candidate matrix: target j offers requester i a response
  always_comb begin
    cand_s = '0;
    for (int i = 0; i < NumInp; i++) begin
      for (int j = 0; j < NumOut; j++) begin
        cand_s[i][j] = rsp_valid_i[j] & ~empty_s[j] & (head_s[j] == IdxWidth'(i));
      end
    end
  end

  // Per-requester grant: locked target if stalled, else round-robin from rr_ptr
  always_comb begin
    int jj;
    jj        = 0;
    gnt_vld_s = '0;
    gnt_sel_s = '0;
    for (int i = 0; i < NumInp; i++) begin
      if (lock_q[i]) begin
        gnt_vld_s[i] = cand_s[i][lock_sel_q[i]];
        gnt_sel_s[i] = lock_sel_q[i];
      end else begin
        for (int k = 0; k < NumOut; k++) begin
          jj = int'(rr_ptr_q[i]) + k;
          if (jj >= NumOut) begin
            jj = jj - NumOut;
          end else begin
            jj = jj;
          end
          if (!gnt_vld_s[i] && cand_s[i][jj]) begin
            gnt_vld_s[i] = 1'b1;
            gnt_sel_s[i] = SelWidth'(jj);
          end else begin
            gnt_vld_s[i] = gnt_vld_s[i];
          end
        end
      end
    end
  end

  // Return the granted target's ready, plus orphan acceptance when enabled
  always_comb begin
    rdy_s = '0;
    for (int j = 0; j < NumOut; j++) begin
      for (int i = 0; i < NumInp; i++) begin
        if (gnt_vld_s[i] && (gnt_sel_s[i] == SelWidth'(j)) && rsp_ready_i[i]) begin
          rdy_s[j] = 1'b1;
        end else begin
          rdy_s[j] = rdy_s[j];
        end
      end
`ifdef STREAM_XBAR_RSP_ORPHAN_EN
      if (rsp_valid_i[j] && empty_s[j]) begin
        rdy_s[j] = 1'b1;
      end else begin
        rdy_s[j] = rdy_s[j];
      end
`endif
    end
  end

  assign rsp_ready_o = rdy_s;
  assign rsp_valid_o = gnt_vld_s;

  // Output payload mux driven by the granted target
  always_comb begin
    rsp_data_o = '0;
    rsp_sel_o  = '0;
    for (int i = 0; i < NumInp; i++) begin
      rsp_data_o[i] = rsp_data_i[gnt_sel_s[i]];
      rsp_sel_o[i]  = gnt_sel_s[i];
    end
  end

  // FIFO pointer and count next-state
  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int j = 0; j < NumOut; j++) begin
      case ({push_s[j], pop_s[j]})
        2'b10:   cnt_d[j] = cnt_q[j] + CntWidth'(1);
        2'b01:   cnt_d[j] = cnt_q[j] - CntWidth'(1);
        default: cnt_d[j] = cnt_q[j];
      endcase
      if (push_s[j]) begin
        wr_ptr_d[j] = ptr_inc(wr_ptr_q[j]);
      end else begin
        wr_ptr_d[j] = wr_ptr_q[j];
      end
      if (pop_s[j]) begin
        rd_ptr_d[j] = ptr_inc(rd_ptr_q[j]);
      end else begin
        rd_ptr_d[j] = rd_ptr_q[j];
      end
    end
  end

  // Arbitration next-state: rr advances past a completed grant, stall locks it
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = '0;
    lock_sel_d = lock_sel_q;
    for (int i = 0; i < NumInp; i++) begin
      if (gnt_vld_s[i] && rsp_ready_i[i]) begin
        rr_ptr_d[i] = sel_inc(gnt_sel_s[i]);
      end else begin
        rr_ptr_d[i] = rr_ptr_q[i];
      end
      lock_d[i]     = gnt_vld_s[i] & ~rsp_ready_i[i];
      lock_sel_d[i] = gnt_sel_s[i];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      lock_q     <= '0;
      lock_sel_q <= '0;
    end else begin
      for (int j = 0; j < NumOut; j++) begin
        if (push_s[j]) begin
          mem_q[j][wr_ptr_q[j]] <= req_idx_i[j];
        end
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
    end
  end

`ifdef STREAM_XBAR_RSP_ORPHAN_EN
  logic err_q;
  logic err_d;

  // Flag any response that arrived at an empty FIFO this cycle
  always_comb begin
    err_d = |(rsp_valid_i & empty_s);
  end

  // Registered orphan pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  stream_xbar_rsp_chk #(
    .NumOut (NumOut)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_req_i (push_req_s),
    .full_i     (full_s),
    .pop_i      (pop_s)
  );

endmodule

// Protocol checker: a push into a full FIFO is only legal alongside a pop.
module stream_xbar_rsp_chk #(
  parameter int NumOut = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  input logic [NumOut-1:0] push_req_i,
  input logic [NumOut-1:0] full_i,
  input logic [NumOut-1:0] pop_i
);

  a_no_push_when_full : assert property (
    @(posedge clk_i) disable iff (rst_i) ((push_req_i & full_i & ~pop_i) == '0)
  ) else $error("stream_xbar_rsp: push into full order FIFO");

endmodule

// File: tb/tb_stream_xbar_rsp.sv
// Directed testbench for stream_xbar_rsp with NumInp=4, NumOut=2, Depth=4, DataWidth=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.

module tb_stream_xbar_rsp;

  logic            clk;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][1:0] req_idx;
  logic [1:0]      full;
  logic [1:0][7:0] rsp_data_in;
  logic [1:0]      rsp_valid_in;
  logic [1:0]      rsp_ready_out;
  logic [3:0][7:0] rsp_data_out;
  logic [3:0][0:0] rsp_sel;
  logic [3:0]      rsp_valid_out;
  logic [3:0]      rsp_ready_in;
  logic            err;

  int n_tests;
  int n_fail;

  stream_xbar_rsp #(
    .NumInp    (4),
    .NumOut    (2),
    .DataWidth (8),
    .Depth     (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_i (req_ready),
    .req_idx_i   (req_idx),
    .full_o      (full),
    .rsp_data_i  (rsp_data_in),
    .rsp_valid_i (rsp_valid_in),
    .rsp_ready_o (rsp_ready_out),
    .rsp_data_o  (rsp_data_out),
    .rsp_sel_o   (rsp_sel),
    .rsp_valid_o (rsp_valid_out),
    .rsp_ready_i (rsp_ready_in),
    .err_o       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid    = 2'b00;
    req_ready    = 2'b11;
    req_idx      = '0;
    rsp_data_in  = '0;
    rsp_valid_in = 2'b00;
    rsp_ready_in = 4'b1111;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++;
      if ({full, rsp_valid_out, rsp_ready_out, err} !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: full=%b valid=%b ready=%b err=%b, required all 0",
                 c, full, rsp_valid_out, rsp_ready_out, err);
      end
      tick();
    end
  endtask

  task automatic test_order();
    req_valid = 2'b01; req_idx[0] = 2'd3;
    tick();
    req_idx[0] = 2'd1;
    tick();
    req_valid = 2'b00;
    rsp_valid_in = 2'b01; rsp_data_in[0] = 8'h0A;
    #1;
    n_tests++;
    if (rsp_valid_out !== 4'b1000 || rsp_data_out[3] !== 8'h0A || rsp_sel[3] !== 1'b0 || rsp_ready_out !== 2'b01) begin
      n_fail++;
      $display("FAIL order_first: valid=%b data3=%h sel3=%b ready=%b, required 1000 0a 0 01",
               rsp_valid_out, rsp_data_out[3], rsp_sel[3], rsp_ready_out);
    end
    tick();
    rsp_data_in[0] = 8'h0B;
    #1;
    n_tests++;
    if (rsp_valid_out !== 4'b0010 || rsp_data_out[1] !== 8'h0B || rsp_sel[1] !== 1'b0 || rsp_ready_out !== 2'b01) begin
      n_fail++;
      $display("FAIL order_second: valid=%b data1=%h sel1=%b ready=%b, required 0010 0b 0 01",
               rsp_valid_out, rsp_data_out[1], rsp_sel[1], rsp_ready_out);
    end
    tick();
    #1;
    n_tests++;
    if (rsp_valid_out !== 4'b0000 || rsp_ready_out !== 2'b00) begin
      n_fail++;
      $display("FAIL order_drained: valid=%b ready=%b, required 0000 00", rsp_valid_out, rsp_ready_out);
    end
    rsp_valid_in = 2'b00;
    tick();
  endtask

  task automatic test_full();
    logic [1:0] exp_head [4];
    exp_head[0] = 2'd1; exp_head[1] = 2'd2; exp_head[2] = 2'd3; exp_head[3] = 2'd2;
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b10; req_idx[1] = 2'(k);
      tick();
    end
    req_valid = 2'b00;
    #1;
    n_tests++;
    if (full !== 2'b10) begin
      n_fail++;
      $display("FAIL full_after_4: full=%b, required 10", full);
    end
    // push and pop in the same cycle while full
    req_valid = 2'b10; req_idx[1] = 2'd2;
    rsp_valid_in = 2'b10; rsp_data_in[1] = 8'h50;
    #1;
    n_tests++;
    if (rsp_valid_out !== 4'b0001 || rsp_data_out[0] !== 8'h50 || rsp_sel[0] !== 1'b1 || rsp_ready_out !== 2'b10) begin
      n_fail++;
      $display("FAIL full_pushpop: valid=%b data0=%h sel0=%b ready=%b, required 0001 50 1 10",
               rsp_valid_out, rsp_data_out[0], rsp_sel[0], rsp_ready_out);
    end
    tick();
    req_valid = 2'b00;
    rsp_valid_in = 2'b00;
    #1;
    n_tests++;
    if (full !== 2'b10) begin
      n_fail++;
      $display("FAIL full_hold: full=%b, required 10", full);
    end
    // drain: remaining heads are 1,2,3 then the refilled 2
    for (int k = 0; k < 4; k++) begin
      rsp_valid_in = 2'b10; rsp_data_in[1] = 8'h60 + 8'(k);
      #1;
      n_tests++;
      if (rsp_valid_out !== (4'b0001 << exp_head[k]) || rsp_data_out[exp_head[k]] !== 8'h60 + 8'(k)) begin
        n_fail++;
        $display("FAIL full_drain %0d: valid=%b data=%h, required valid bit %0d data %h",
                 k, rsp_valid_out, rsp_data_out[exp_head[k]], exp_head[k], 8'h60 + 8'(k));
      end
      tick();
      if (k == 0) begin
        n_tests++;
        if (full !== 2'b00) begin
          n_fail++;
          $display("FAIL full_release: full=%b, required 00", full);
        end
      end
    end
    rsp_valid_in = 2'b00;
    #1;
    n_tests++;
    if (rsp_valid_out !== 4'b0000 || full !== 2'b00) begin
      n_fail++;
      $display("FAIL full_empty: valid=%b full=%b, required 0000 00", rsp_valid_out, full);
    end
    tick();
  endtask

  task automatic test_lock();
    req_valid = 2'b11; req_idx[0] = 2'd2; req_idx[1] = 2'd2;
    tick();
    req_valid = 2'b00;
    rsp_valid_in = 2'b11; rsp_data_in[0] = 8'h10; rsp_data_in[1] = 8'h20;
    rsp_ready_in = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (rsp_valid_out !== 4'b0100 || rsp_data_out[2] !== 8'h10 || rsp_sel[2] !== 1'b0 || rsp_ready_out !== 2'b00) begin
        n_fail++;
        $display("FAIL lock_stall %0d: valid=%b data2=%h sel2=%b ready=%b, required 0100 10 0 00",
                 c, rsp_valid_out, rsp_data_out[2], rsp_sel[2], rsp_ready_out);
      end
      tick();
    end
    rsp_ready_in = 4'b1111;
    #1;
    n_tests++;
    if (rsp_data_out[2] !== 8'h10 || rsp_sel[2] !== 1'b0 || rsp_ready_out !== 2'b01) begin
      n_fail++;
      $display("FAIL lock_release: data2=%h sel2=%b ready=%b, required 10 0 01",
               rsp_data_out[2], rsp_sel[2], rsp_ready_out);
    end
    tick();
    #1;
    n_tests++;
    if (rsp_valid_out !== 4'b0100 || rsp_data_out[2] !== 8'h20 || rsp_sel[2] !== 1'b1 || rsp_ready_out !== 2'b10) begin
      n_fail++;
      $display("FAIL lock_next: valid=%b data2=%h sel2=%b ready=%b, required 0100 20 1 10",
               rsp_valid_out, rsp_data_out[2], rsp_sel[2], rsp_ready_out);
    end
    tick();
    rsp_valid_in = 2'b00;
    tick();
  endtask

  task automatic test_same_cycle();
    req_valid = 2'b01; req_idx[0] = 2'd1;
    rsp_valid_in = 2'b01; rsp_data_in[0] = 8'h33;
    #1;
    n_tests++;
`ifdef STREAM_XBAR_RSP_ORPHAN_EN
    if (rsp_ready_out !== 2'b01 || rsp_valid_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL same_cycle_nobypass: ready=%b valid=%b, required 01 0000", rsp_ready_out, rsp_valid_out);
    end
`else
    if (rsp_ready_out !== 2'b00 || rsp_valid_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL same_cycle_nobypass: ready=%b valid=%b, required 00 0000", rsp_ready_out, rsp_valid_out);
    end
`endif
    tick();
    req_valid = 2'b00;
    #1;
    n_tests++;
    if (rsp_valid_out !== 4'b0010 || rsp_data_out[1] !== 8'h33 || rsp_ready_out !== 2'b01) begin
      n_fail++;
      $display("FAIL same_cycle_deliver: valid=%b data1=%h ready=%b, required 0010 33 01",
               rsp_valid_out, rsp_data_out[1], rsp_ready_out);
    end
    tick();
    rsp_valid_in = 2'b00;
    tick();
  endtask

  task automatic test_orphan();
    rsp_valid_in = 2'b10; rsp_data_in[1] = 8'h77;
`ifdef STREAM_XBAR_RSP_ORPHAN_EN
    #1;
    n_tests++;
    if (rsp_ready_out !== 2'b10 || rsp_valid_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL orphan_accept: ready=%b valid=%b, required 10 0000", rsp_ready_out, rsp_valid_out);
    end
    tick();
    rsp_valid_in = 2'b00;
    #1;
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL orphan_err: err=%b, required 1", err);
    end
    tick();
    #1;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL orphan_err_clear: err=%b, required 0", err);
    end
`else
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++;
      if (rsp_ready_out !== 2'b00 || rsp_valid_out !== 4'b0000 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL orphan_stall %0d: ready=%b valid=%b err=%b, required 00 0000 0",
                 c, rsp_ready_out, rsp_valid_out, err);
      end
      tick();
    end
    rsp_valid_in = 2'b00;
`endif
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle_inputs();
    test_reset();
    test_order();
    test_full();
    test_lock();
    test_same_cycle();
    test_orphan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
